// File: rtl/cracker_host_pkg.sv
// rtl/cracker_host_pkg.sv - shared sizes and state encoding for the cracker host driver
package cracker_host_pkg;
   localparam int HASH_BYTES   = 16;
   localparam int PW_BYTES     = 20;
   localparam int RESULT_BYTES = 21;

   typedef enum logic [3:0] {
      IDLE,
      LD_WAIT,
      LD_SETUP,
      LD_STROBE,
      LD_REL,
      GO_WAIT,
      GO_STROBE,
      GO_REL,
      POLL,
      RD_CAPT,
      RD_STROBE,
      RD_REL,
      EMIT,
      DONE
   } state_t;
endpackage

// File: rtl/cracker_host_driver_strobe_timer.sv
// rtl/cracker_host_driver_strobe_timer.sv - down-counter that times every strobe pulse
module strobe_timer #(
   parameter int CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   output logic o_done
);
   localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [W-1:0] r_cnt;

   // Loaded on entry to a strobe state, so done rises in the strobe's last cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= W'(CYCLES - 1);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_done = (r_cnt == '0);
endmodule

// File: rtl/cracker_host_driver.sv
// rtl/cracker_host_driver.sv - host-side handshake engine loading a hash and collecting cracked passwords
module cracker_host_driver
   import cracker_host_pkg::*;
#(
   parameter int STROBE_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] hash_in,
   input  logic         hash_valid,
   output logic         hash_ready,
   input  logic         start,
   output logic         busy,
   output logic [7:0]   new_hash_byte,
   output logic         store_hash_byte,
   output logic         go,
   input  logic         my_turn,
   input  logic         match_found,
   input  logic [7:0]   password_byte,
   output logic [159:0] result_password,
   output logic [7:0]   result_length,
   output logic         result_valid,
   input  logic         result_ready,
   output logic         search_done,
   output logic [7:0]   found_count
);
   state_t         r_state;
   state_t         w_next;
   logic [127:0]   r_hash;
   logic [3:0]     r_idx;
   logic [4:0]     r_k;
   logic [7:0]     r_byte;
   logic [159:0]   r_pw;
   logic [7:0]     r_len;
   logic [7:0]     r_found;
   logic           r_store;
   logic           r_go;
   logic           w_tmr_load;
   logic           w_tmr_done;
   logic           w_next_strobe;
   logic [4:0]     w_pw_sel;

   strobe_timer #(.CYCLES(STROBE_CYCLES)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_tmr_load),
      .o_done (w_tmr_done)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (hash_valid) w_next = LD_WAIT;
                    else if (start) w_next = GO_WAIT;
         LD_WAIT:   if (my_turn) w_next = LD_SETUP;
         LD_SETUP:  w_next = LD_STROBE;
         LD_STROBE: if (w_tmr_done) w_next = LD_REL;
         LD_REL:    w_next = (r_idx == 4'(HASH_BYTES - 1)) ? IDLE : LD_WAIT;
         GO_WAIT:   if (my_turn) w_next = GO_STROBE;
         GO_STROBE: if (w_tmr_done) w_next = GO_REL;
         GO_REL:    w_next = POLL;
         POLL:      if (my_turn) w_next = match_found ? RD_CAPT : DONE;
         RD_CAPT:   if (my_turn) w_next = RD_STROBE;
         RD_STROBE: if (w_tmr_done) w_next = RD_REL;
         RD_REL:    w_next = (r_k == 5'(RESULT_BYTES - 1)) ? EMIT : RD_CAPT;
         EMIT:      if (result_ready) w_next = POLL;
         DONE:      w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   assign w_next_strobe = (w_next == LD_STROBE) || (w_next == GO_STROBE) || (w_next == RD_STROBE);
   assign w_tmr_load    = w_next_strobe && (w_next != r_state);
   // First password byte read lands in the top byte of the result word.
   assign w_pw_sel      = 5'(PW_BYTES - 1) - r_k;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_hash  <= '0;
         r_idx   <= '0;
         r_k     <= '0;
         r_byte  <= '0;
         r_pw    <= '0;
         r_len   <= '0;
         r_found <= '0;
         r_store <= 1'b0;
         r_go    <= 1'b0;
      end else begin
         r_state <= w_next;
         // Strobes follow the next state so they line up exactly with the strobe states.
         r_store <= (w_next == LD_STROBE);
         r_go    <= (w_next == GO_STROBE) || (w_next == RD_STROBE);
         case (r_state)
            IDLE: begin
               if (hash_valid) begin
                  r_hash <= hash_in;
                  r_idx  <= '0;
               end else if (start) begin
                  r_found <= '0;
               end
            end
            LD_WAIT: if (my_turn) r_byte <= r_hash[{r_idx, 3'b000} +: 8];
            LD_REL:  if (r_idx != 4'(HASH_BYTES - 1)) r_idx <= r_idx + 4'd1;
            POLL:    if (my_turn && match_found) r_k <= '0;
            RD_CAPT: begin
               if (my_turn) begin
                  if (r_k == 5'(RESULT_BYTES - 1)) r_len <= password_byte;
                  else r_pw[{w_pw_sel, 3'b000} +: 8] <= password_byte;
               end
            end
            RD_REL:  if (r_k != 5'(RESULT_BYTES - 1)) r_k <= r_k + 5'd1;
            EMIT:    if (result_ready) r_found <= r_found + 8'd1;
            default: ;
         endcase
      end
   end

   assign hash_ready      = (r_state == IDLE);
   assign busy            = (r_state != IDLE);
   assign new_hash_byte   = r_byte;
   assign store_hash_byte = r_store;
   assign go              = r_go;
   assign result_password = r_pw;
   assign result_length   = r_len;
   assign result_valid    = (r_state == EMIT);
   assign search_done     = (r_state == DONE);
   assign found_count     = r_found;
endmodule
